// File: rtl/io_port_bank.sv
// Z80 I/O port bank: NWR address-decoded write latches with optional self-lock,
// plus a registered priority mux over NRD read sources driving a shared data-out bus.

module io_wr_port #(
  parameter int             DW       = 8,
  parameter logic [15:0]    ADDR     = '0,
  parameter logic [15:0]    MASK     = '1,
  parameter logic [DW-1:0]  RST_VAL  = '0,
  parameter logic           LOCK_EN  = 1'b0,
  parameter logic [2:0]     LOCK_BIT = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [15:0]   a_i,
  input  logic [DW-1:0] d_i,
  input  logic          commit_i,
  input  logic          wr_en_i,
  input  logic          unlock_i,
  output logic [DW-1:0] q_o,
  output logic          stb_o,
  output logic          locked_o
);
  if (LOCK_BIT >= DW) begin : g_lock_bit_chk
    $error("io_wr_port: LOCK_BIT out of range for DW");
  end

  logic [DW-1:0] q_q;
  logic          stb_q;
  logic          hit, wr_ok;

  assign hit      = commit_i & wr_en_i & (((a_i ^ ADDR) & MASK) == 16'h0000);
  assign locked_o = LOCK_EN & (|(q_q & (DW'(1) << LOCK_BIT))) & ~unlock_i;
  assign wr_ok    = hit & ~locked_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q   <= RST_VAL;
      stb_q <= 1'b0;
    end else begin
      stb_q <= wr_ok;
      if (wr_ok) q_q <= d_i;
    end
  end

  assign q_o   = q_q;
  assign stb_o = stb_q;
endmodule

module io_port_bank #(
  parameter int                 NWR      = 4,
  parameter int                 NRD      = 2,
  parameter int                 DW       = 8,
  parameter logic [NWR*16-1:0]  WR_ADDR  = '0,
  parameter logic [NWR*16-1:0]  WR_MASK  = '1,
  parameter logic [NWR*DW-1:0]  WR_RESET = '0,
  parameter logic [NWR-1:0]     LOCK_EN  = '0,
  parameter logic [NWR*3-1:0]   LOCK_BIT = '0,
  parameter logic [NRD*16-1:0]  RD_ADDR  = '0,
  parameter logic [NRD*16-1:0]  RD_MASK  = '1
) (
  input  logic                    clk28,
  input  logic                    rst,
  input  logic [15:0]             a,
  input  logic [DW-1:0]           d,
  input  logic                    ioreq,
  input  logic                    rd,
  input  logic                    wr,
  input  logic [NWR-1:0]          wr_en,
  input  logic [NRD-1:0]          rd_en,
  input  logic                    unlock,
  input  logic [NRD-1:0][DW-1:0]  rd_data,
  output logic [NWR-1:0][DW-1:0]  port_q,
  output logic [NWR-1:0]          wr_stb,
  output logic [NWR-1:0]          locked,
  output logic [DW-1:0]           d_out,
  output logic                    d_out_active
);
  localparam int IW = (NRD > 1) ? $clog2(NRD) : 1;

  // Previous-cycle write flag resets high so a write straddling reset release never commits.
  logic wcyc, wcyc_prev_q, commit;
  assign wcyc   = ioreq & wr;
  assign commit = wcyc & ~wcyc_prev_q;

  always_ff @(posedge clk28) begin
    if (rst) wcyc_prev_q <= 1'b1;
    else     wcyc_prev_q <= wcyc;
  end

  for (genvar i = 0; i < NWR; i++) begin : g_wr
    io_wr_port #(
      .DW       (DW),
      .ADDR     (WR_ADDR[16*i +: 16]),
      .MASK     (WR_MASK[16*i +: 16]),
      .RST_VAL  (WR_RESET[DW*i +: DW]),
      .LOCK_EN  (LOCK_EN[i]),
      .LOCK_BIT (LOCK_BIT[3*i +: 3])
    ) u_port (
      .clk_i    (clk28),
      .rst_i    (rst),
      .a_i      (a),
      .d_i      (d),
      .commit_i (commit),
      .wr_en_i  (wr_en[i]),
      .unlock_i (unlock),
      .q_o      (port_q[i]),
      .stb_o    (wr_stb[i]),
      .locked_o (locked[i])
    );
  end

  logic [NRD-1:0] rd_hit;
  for (genvar j = 0; j < NRD; j++) begin : g_rd
    assign rd_hit[j] = ioreq & rd & rd_en[j] &
                       (((a ^ RD_ADDR[16*j +: 16]) & RD_MASK[16*j +: 16]) == 16'h0000);
  end

  logic [IW-1:0] sel_d, sel_q;
  logic          act_q;

  always_comb begin
    sel_d = '0;
    for (int j = NRD-1; j >= 0; j--) begin
      if (rd_hit[j]) sel_d = IW'(j);
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      sel_q <= '0;
      act_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      act_q <= |rd_hit;
    end
  end

  // Data is picked live from the registered index so source changes show through.
  assign d_out        = act_q ? rd_data[sel_q] : '1;
  assign d_out_active = act_q;
endmodule
